// File: rtl/cpu1_mulx_sequencer.sv
// Multiply sequencer feeding and consuming the CPU1 32x32 low-word multiplier cell.
// MUL issues once; MULX* issues four 16x16 partial products and returns the corrected high word.
// Optional flush input enabled by CPU1_MULX_FLUSH_EN.
module cpu1_mulx_sequencer #(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef CPU1_MULX_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  input  logic [31:0] cell_result,
  output logic        resp_valid,
  output logic [31:0] resp_result
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CORR, RESP} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_MULXUU, OP_MULXSS, OP_MULXSU} op_t;

  // Travels alongside each issued operand pair so the return knows how to be used.
  typedef struct packed {
    logic       valid;
    logic       last;
    logic [1:0] beat;
  } tag_t;

  state_t      state, state_next;
  op_t         op;
  logic [31:0] src_a, src_b;
  logic [63:0] acc;
  logic [1:0]  beat;
  tag_t        tag_pipe [CELL_LATENCY];
  tag_t        tag_in, tag_out;
  logic        accept, kill;
  logic [63:0] addend;
  logic [31:0] hi, corr_a, corr_b, hi_corr;

`ifdef CPU1_MULX_FLUSH_EN
  assign kill = flush && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  assign accept  = req_valid && req_ready;
  assign tag_out = tag_pipe[CELL_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block is assigned a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    cell_src1  = '0;
    cell_src2  = '0;
    tag_in     = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        tag_in.valid = 1'b1;
        tag_in.beat  = beat;
        if (op == OP_MUL) begin
          cell_src1   = src_a;
          cell_src2   = src_b;
          tag_in.last = 1'b1;
          state_next  = DRAIN;
        end else begin
          case (beat)
            2'd0: begin cell_src1 = {16'h0, src_a[15:0]};  cell_src2 = {16'h0, src_b[15:0]};  end
            2'd1: begin cell_src1 = {16'h0, src_a[31:16]}; cell_src2 = {16'h0, src_b[15:0]};  end
            2'd2: begin cell_src1 = {16'h0, src_a[15:0]};  cell_src2 = {16'h0, src_b[31:16]}; end
            default: begin cell_src1 = {16'h0, src_a[31:16]}; cell_src2 = {16'h0, src_b[31:16]}; end
          endcase
          tag_in.last = (beat == 2'd3);
          if (beat == 2'd3) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_out.valid && tag_out.last) state_next = (op == OP_MUL) ? RESP : CORR;
      end
      CORR: state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A flush still lets a RESP pulse out; it only forces the next state.
    if (kill) begin
      state_next = IDLE;
      tag_in     = '0;
    end
  end

  always_comb begin
    addend = '0;
    case (tag_out.beat)
      2'd0:    addend = {32'h0, cell_result};
      2'd1,
      2'd2:    addend = {16'h0, cell_result, 16'h0};
      default: addend = {cell_result, 32'h0};
    endcase
  end

  // Signed correction of the unsigned 64-bit product's high word, modulo 2^32.
  always_comb begin
    hi      = acc[63:32];
    corr_a  = src_a[31] ? src_b : 32'h0;
    corr_b  = src_b[31] ? src_a : 32'h0;
    hi_corr = hi;
    case (op)
      OP_MULXSS: hi_corr = hi - corr_a - corr_b;
      OP_MULXSU: hi_corr = hi - corr_a;
      default:   hi_corr = hi;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      op          <= OP_MUL;
      src_a       <= '0;
      src_b       <= '0;
      acc         <= '0;
      beat        <= '0;
      resp_result <= '0;
      // NOTE: the tag pipe is reset explicitly, since stale valid tags would corrupt the next op.
      for (int i = 0; i < CELL_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < CELL_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (kill) begin
        for (int i = 0; i < CELL_LATENCY; i++) tag_pipe[i] <= '0;
      end

      if (accept) begin
        op    <= op_t'(req_op);
        src_a <= req_src1;
        src_b <= req_src2;
        acc   <= '0;
        beat  <= '0;
      end else if (state == ISSUE) begin
        beat <= beat + 2'd1;
      end

      if (tag_out.valid && !kill) begin
        if (op == OP_MUL) resp_result <= cell_result;
        else              acc         <= acc + addend;
      end

      if (state == CORR && !kill) resp_result <= hi_corr;
    end
  end

endmodule

// File: tb/tb_cpu1_mulx_sequencer.sv
// Bench for cpu1_mulx_sequencer at CELL_LATENCY=1 with a registered low-32 multiply cell model.
// Expected results go into a scoreboard at accept and are compared when resp_valid arrives.
module tb_cpu1_mulx_sequencer;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic [31:0] cell_src1, cell_src2, cell_result;
  logic        resp_valid;
  logic [31:0] resp_result;
`ifdef CPU1_MULX_FLUSH_EN
  logic        flush = 1'b0;
`endif

  cpu1_mulx_sequencer #(.CELL_LATENCY(L)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef CPU1_MULX_FLUSH_EN
    .flush       (flush),
`endif
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .cell_src1   (cell_src1),
    .cell_src2   (cell_src2),
    .cell_result (cell_result),
    .resp_valid  (resp_valid),
    .resp_result (resp_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cell_result <= cell_src1 * cell_src2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          t_acc;
    int          lat;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        check("spurious_resp_valid", {31'h0, resp_valid}, 32'h0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("resp_result", resp_result, e.res);
        check("resp_latency", 32'(cyc - e.t_acc), 32'(e.lat));
      end
    end
  end

  // Starts and ends on a falling edge; returns in the cycle after the accept.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] want, input bit push, input bit hold, output int t);
    bit ok;
    ok        = 1'b0;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", {31'h0, req_ready}, 32'h1);
    t = cyc;
    if (push) sb.push_back('{res: want, t_acc: cyc, lat: (op == 2'b00) ? L + 2 : L + 6});
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 32'(sb.size()), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    int   t1, t2;

    vecs[0] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[4] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[5] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[6] = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
    vecs[7] = '{2'b11, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[8] = '{2'b01, 32'h0001_8000, 32'h0002_0000, 32'h0000_0003};
    vecs[9] = '{2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_src1  = '0;
    req_src2  = '0;
    repeat (3) @(negedge clk);
    check("reset_req_ready",   {31'h0, req_ready},  32'h1);
    check("reset_resp_valid",  {31'h0, resp_valid}, 32'h0);
    check("reset_resp_result", resp_result,         32'h0);
    check("reset_cell_src1",   cell_src1,           32'h0);
    check("reset_cell_src2",   cell_src2,           32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].want, 1'b1, 1'b0, t1);
      wait_drain();
    end

    // MUL drives the cell operands for exactly one cycle.
    send(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b1, 1'b0, t1);
    check("mul_cell_src1_t1", cell_src1, 32'h0001_0003);
    check("mul_cell_src2_t1", cell_src2, 32'h0002_0005);
    @(negedge clk);
    check("mul_cell_src1_t2", cell_src1, 32'h0);
    check("mul_cell_src2_t2", cell_src2, 32'h0);
    wait_drain();

    // MULX keeps req_ready low from T+1 through T+6.
    send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, t1);
    for (int i = 1; i <= 6; i++) begin
      check("mulx_busy_req_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    wait_drain();

    // Back-to-back with req_valid held: second accept lands on the cycle after RESP.
    send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b1, t1);
    send(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b1, 1'b0, t2);
    check("b2b_accept_gap", 32'(t2 - t1), 32'(L + 7));
    wait_drain();

    // Reset at T+3 of a MULXSS kills it.
    send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, t1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_reset_req_ready", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      check("post_reset_no_resp", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
    end
    send(2'b00, 32'h7, 32'h6, 32'h0000_002A, 1'b1, 1'b0, t1);
    wait_drain();

`ifdef CPU1_MULX_FLUSH_EN
    // Flush at T+5 of a MULXUU kills it.
    send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, t1);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("post_flush_req_ready", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      check("post_flush_no_resp", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
    end
    send(2'b00, 32'h3, 32'h3, 32'h0000_0009, 1'b1, 1'b0, t1);
    wait_drain();
`endif

    check("final_resp_result_hold", resp_result,
`ifdef CPU1_MULX_FLUSH_EN
          32'h0000_0009
`else
          32'h0000_002A
`endif
    );

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
